// File: rtl/eth_mdio_phy_slave.sv
// MDIO (clause 22) PHY-side management slave.
// MDC and MDIO are synchronised into av_clk; every protocol step happens on a
// synchronised MDC rising edge ("tick"). Read data is fetched from the register
// file through rd_regad/rd_data. Write data is presented on wr_regad/wr_data,
// qualified by wr_valid.
module eth_mdio_phy_slave #(
    parameter logic [4:0] PHY_ADDR = 5'd1,
    parameter int         PRE_BITS = 32,
    parameter bit         BCAST_EN = 1'b0
) (
    input  logic        av_clk,
    input  logic        av_reset,
    input  logic        mdc_i,
    input  logic        md_i,
    output logic        md_o,
    output logic        md_oe,
    output logic [4:0]  rd_regad,
    output logic        rd_strobe,
    input  logic [15:0] rd_data,
    output logic        wr_valid,
    output logic [4:0]  wr_regad,
    output logic [15:0] wr_data
);

    localparam int PW = $clog2(PRE_BITS + 1);
    localparam logic [PW-1:0] PRE_MAX  = PW'(PRE_BITS);
    localparam logic [PW-1:0] PRE_ZERO = PW'(1'b0);
    localparam logic [PW-1:0] PRE_ONE  = PW'(1'b1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ST    = 3'd1,
        S_OP    = 3'd2,
        S_PHYAD = 3'd3,
        S_REGAD = 3'd4,
        S_TA    = 3'd5,
        S_RDATA = 3'd6,
        S_WDATA = 3'd7
    } state_t;

    // Synchroniser flops and the previous synchronised MDC value.
    logic [1:0] mdc_sync_q;
    logic       mdc_prev_q;
    logic [1:0] md_sync_q;

    // Protocol state.
    state_t      state_q,     state_d;
    logic [3:0]  bit_cnt_q,   bit_cnt_d;
    logic [PW-1:0] pre_cnt_q, pre_cnt_d;
    logic        op_hi_q,     op_hi_d;
    logic        is_read_q,   is_read_d;
    logic        match_q,     match_d;
    logic [4:0]  phyad_q,     phyad_d;
    logic [4:0]  regad_q,     regad_d;
    logic [15:0] shift_q,     shift_d;

    // Registered outputs.
    logic        md_o_q,      md_o_d;
    logic        md_oe_q,     md_oe_d;
    logic        rd_strobe_q, rd_strobe_d;
    logic        wr_valid_q,  wr_valid_d;
    logic [4:0]  rd_regad_q,  rd_regad_d;
    logic [4:0]  wr_regad_q,  wr_regad_d;
    logic [15:0] wr_data_q,   wr_data_d;

    logic        tick_s;
    logic        md_bit_s;
    logic        match_s;
    logic [4:0]  regad_next_s;
    logic [15:0] shift_in_s;
    logic [15:0] shift_out_s;

    assign tick_s       = mdc_sync_q[1] & ~mdc_prev_q;
    assign md_bit_s     = md_sync_q[1];
    assign regad_next_s = {regad_q[3:0], md_bit_s};
    assign shift_in_s   = {shift_q[14:0], md_bit_s};
    assign shift_out_s  = {shift_q[14:0], 1'b0};
    // Broadcast address 0 is honoured for writes only; reads must never drive the bus.
    assign match_s      = (phyad_q == PHY_ADDR) ||
                          (BCAST_EN && (phyad_q == 5'd0) && !is_read_q);

    // Two-flop synchronisers for MDC and MDIO plus MDC edge history.
    always_ff @(posedge av_clk or posedge av_reset) begin
        if (av_reset) begin
            mdc_sync_q <= 2'b00;
            mdc_prev_q <= 1'b0;
            md_sync_q  <= 2'b00;
        end else begin
            mdc_sync_q <= {mdc_sync_q[0], mdc_i};
            mdc_prev_q <= mdc_sync_q[1];
            md_sync_q  <= {md_sync_q[0], md_i};
        end
    end

    // Protocol state and output registers.
    always_ff @(posedge av_clk or posedge av_reset) begin
        if (av_reset) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= 4'd0;
            pre_cnt_q   <= PRE_ZERO;
            op_hi_q     <= 1'b0;
            is_read_q   <= 1'b0;
            match_q     <= 1'b0;
            phyad_q     <= 5'd0;
            regad_q     <= 5'd0;
            shift_q     <= 16'd0;
            md_o_q      <= 1'b0;
            md_oe_q     <= 1'b0;
            rd_strobe_q <= 1'b0;
            wr_valid_q  <= 1'b0;
            rd_regad_q  <= 5'd0;
            wr_regad_q  <= 5'd0;
            wr_data_q   <= 16'd0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            pre_cnt_q   <= pre_cnt_d;
            op_hi_q     <= op_hi_d;
            is_read_q   <= is_read_d;
            match_q     <= match_d;
            phyad_q     <= phyad_d;
            regad_q     <= regad_d;
            shift_q     <= shift_d;
            md_o_q      <= md_o_d;
            md_oe_q     <= md_oe_d;
            rd_strobe_q <= rd_strobe_d;
            wr_valid_q  <= wr_valid_d;
            rd_regad_q  <= rd_regad_d;
            wr_regad_q  <= wr_regad_d;
            wr_data_q   <= wr_data_d;
        end
    end

    // Frame decoder: next state and outputs, evaluated only on MDC ticks.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        pre_cnt_d   = pre_cnt_q;
        op_hi_d     = op_hi_q;
        is_read_d   = is_read_q;
        match_d     = match_q;
        phyad_d     = phyad_q;
        regad_d     = regad_q;
        shift_d     = shift_q;
        md_o_d      = md_o_q;
        md_oe_d     = md_oe_q;
        rd_strobe_d = 1'b0;
        wr_valid_d  = 1'b0;
        rd_regad_d  = rd_regad_q;
        wr_regad_d  = wr_regad_q;
        wr_data_d   = wr_data_q;

        if (tick_s) begin
            case (state_q)
                S_IDLE: begin
                    if (md_bit_s) begin
                        if (pre_cnt_q != PRE_MAX) begin
                            pre_cnt_d = pre_cnt_q + PRE_ONE;
                        end else begin
                            pre_cnt_d = pre_cnt_q;
                        end
                    end else if (pre_cnt_q == PRE_MAX) begin
                        // This 0 is the first start bit.
                        state_d   = S_ST;
                        pre_cnt_d = PRE_ZERO;
                    end else begin
                        pre_cnt_d = PRE_ZERO;
                    end
                end
                S_ST: begin
                    if (md_bit_s) begin
                        state_d   = S_OP;
                        bit_cnt_d = 4'd0;
                    end else begin
                        state_d   = S_IDLE;
                        pre_cnt_d = PRE_ZERO;
                    end
                end
                S_OP: begin
                    if (bit_cnt_q == 4'd0) begin
                        op_hi_d   = md_bit_s;
                        bit_cnt_d = 4'd1;
                    end else if (op_hi_q != md_bit_s) begin
                        // 10 is a read, 01 is a write.
                        state_d   = S_PHYAD;
                        is_read_d = op_hi_q;
                        bit_cnt_d = 4'd0;
                    end else begin
                        state_d   = S_IDLE;
                        pre_cnt_d = PRE_ZERO;
                    end
                end
                S_PHYAD: begin
                    phyad_d = {phyad_q[3:0], md_bit_s};
                    if (bit_cnt_q == 4'd4) begin
                        state_d   = S_REGAD;
                        bit_cnt_d = 4'd0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
                S_REGAD: begin
                    regad_d = regad_next_s;
                    if (bit_cnt_q == 4'd4) begin
                        match_d   = match_s;
                        state_d   = S_TA;
                        bit_cnt_d = 4'd0;
                        if (match_s && is_read_q) begin
                            rd_regad_d = regad_next_s;
                        end else begin
                            rd_regad_d = rd_regad_q;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
                S_TA: begin
                    if (bit_cnt_q == 4'd0) begin
                        bit_cnt_d = 4'd1;
                        if (is_read_q && match_q) begin
                            // Register file has had a full MDC period to settle.
                            shift_d     = rd_data;
                            rd_strobe_d = 1'b1;
                            md_oe_d     = 1'b1;
                            md_o_d      = 1'b0;
                        end else begin
                            md_oe_d = md_oe_q;
                        end
                    end else begin
                        bit_cnt_d = 4'd0;
                        if (is_read_q) begin
                            state_d = S_RDATA;
                            if (match_q) begin
                                md_o_d  = shift_q[15];
                                shift_d = shift_out_s;
                            end else begin
                                md_o_d = 1'b0;
                            end
                        end else begin
                            state_d = S_WDATA;
                        end
                    end
                end
                S_RDATA: begin
                    if (bit_cnt_q == 4'd15) begin
                        state_d   = S_IDLE;
                        pre_cnt_d = PRE_ZERO;
                        md_oe_d   = 1'b0;
                        md_o_d    = 1'b0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (match_q) begin
                            md_o_d  = shift_q[15];
                            shift_d = shift_out_s;
                        end else begin
                            md_o_d = 1'b0;
                        end
                    end
                end
                S_WDATA: begin
                    shift_d = shift_in_s;
                    if (bit_cnt_q == 4'd15) begin
                        state_d   = S_IDLE;
                        pre_cnt_d = PRE_ZERO;
                        if (match_q) begin
                            wr_regad_d = regad_q;
                            wr_data_d  = shift_in_s;
                            wr_valid_d = 1'b1;
                        end else begin
                            wr_valid_d = 1'b0;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
                default: begin
                    state_d   = S_IDLE;
                    pre_cnt_d = PRE_ZERO;
                    md_oe_d   = 1'b0;
                    md_o_d    = 1'b0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    assign md_o      = md_o_q;
    assign md_oe     = md_oe_q;
    assign rd_strobe = rd_strobe_q;
    assign wr_valid  = wr_valid_q;
    assign rd_regad  = rd_regad_q;
    assign wr_regad  = wr_regad_q;
    assign wr_data   = wr_data_q;

endmodule
